pipeline_ctrl: RTL and testbench

Central stall/flush sequencer for the five-stage pipeline. It merges the decode-stage load-use stall request, multi-cycle execute operations (mult/div) and mem-stage exception redirects into one per-stage stall vector, a flush pulse and a redirect PC. Its multi-cycle counter holds the front of the pipeline while execute finishes. It sits beside the stage registers and drives every pipeline register's stall/flush inputs plus the PC mux.

---
 rtl/pipeline_ctrl_pkg.sv | 18 +
 rtl/pipeline_ctrl_sat_counter.sv | 18 +
 rtl/pipeline_ctrl.sv | 122 ++++++++++++
 tb/tb_pipeline_ctrl.sv | 201 ++++++++++++++++++++
 4 files changed

// File: rtl/pipeline_ctrl_pkg.sv
// Shared encodings for the pipeline stall/flush sequencer.
// Stall vector bits: 0 pc, 1 if, 2 id, 3 ex, 4 mem, 5 wb.
package pipeline_ctrl_pkg;

    localparam int InstAddrW = 32;
    localparam int McLenW    = 6;

    localparam logic [5:0] StallNone = 6'b000000;
    localparam logic [5:0] StallId   = 6'b000111;
    localparam logic [5:0] StallEx   = 6'b001111;

    typedef enum logic [1:0] {
        CtrlRun   = 2'd0,
        CtrlMc    = 2'd1,
        CtrlFlush = 2'd2
    } ctrl_state_t;

endpackage

// File: rtl/pipeline_ctrl_sat_counter.sv
// 32-bit event counter that sticks at all-ones instead of wrapping.
// Used by pipeline_ctrl for its optional performance counters.
module sat_counter (
    input  logic        clk,
    input  logic        rst,
    input  logic        en,
    output logic [31:0] count
);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            count <= '0;
        end else if (en && (count != 32'hFFFF_FFFF)) begin
            count <= count + 32'd1;
        end
    end

endmodule

// File: rtl/pipeline_ctrl.sv
// Stall/flush sequencer: merges load-use, multi-cycle and redirect requests.
// Optional perf counters are built when STALL_CTRL_PERF_EN is defined.
module pipeline_ctrl
    import pipeline_ctrl_pkg::*;
#(
    parameter int MC_LEN_W = McLenW
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 stallreq_id_i,
    input  logic                 mc_start_i,
    input  logic [MC_LEN_W-1:0]  mc_len_i,
    input  logic                 flush_req_i,
    input  logic [InstAddrW-1:0] flush_pc_i,
    output logic [5:0]           stall_o,
    output logic                 flush_o,
    output logic [InstAddrW-1:0] new_pc_o,
`ifdef STALL_CTRL_PERF_EN
    output logic [31:0]          stall_cycles_o,
    output logic [31:0]          flush_count_o,
`endif
    output logic                 busy_o
);

    localparam logic [MC_LEN_W-1:0] LenOne = MC_LEN_W'(1);

    ctrl_state_t           state;
    ctrl_state_t           state_nxt;
    logic [MC_LEN_W-1:0]   cnt;
    logic [MC_LEN_W-1:0]   cnt_nxt;
    logic                  flush_nxt;
    logic [InstAddrW-1:0]  pc_nxt;
    logic [5:0]            stall_raw;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state    <= CtrlRun;
            cnt      <= '0;
            flush_o  <= 1'b0;
            new_pc_o <= '0;
        end else begin
            state    <= state_nxt;
            cnt      <= cnt_nxt;
            flush_o  <= flush_nxt;
            new_pc_o <= pc_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        flush_nxt = 1'b0;
        pc_nxt    = new_pc_o;
        stall_raw = StallNone;
        unique case (state)
            CtrlRun: begin
                if (flush_req_i) begin
                    state_nxt = CtrlFlush;
                    flush_nxt = 1'b1;
                    pc_nxt    = flush_pc_i;
                end else if (mc_start_i && (mc_len_i != '0)) begin
                    stall_raw = StallEx;
                    if (mc_len_i > LenOne) begin
                        state_nxt = CtrlMc;
                        cnt_nxt   = mc_len_i - LenOne;
                    end
                end else if (stallreq_id_i) begin
                    stall_raw = StallId;
                end
            end
            CtrlMc: begin
                if (flush_req_i) begin
                    state_nxt = CtrlFlush;
                    cnt_nxt   = '0;
                    flush_nxt = 1'b1;
                    pc_nxt    = flush_pc_i;
                end else begin
                    stall_raw = StallEx;
                    if (cnt == LenOne) begin
                        state_nxt = CtrlRun;
                        cnt_nxt   = '0;
                    end else begin
                        cnt_nxt = cnt - LenOne;
                    end
                end
            end
            CtrlFlush: begin
                // A fresh redirect while flushing re-arms with the newer target
                if (flush_req_i) begin
                    flush_nxt = 1'b1;
                    pc_nxt    = flush_pc_i;
                end else begin
                    state_nxt = CtrlRun;
                end
            end
            default: begin
                state_nxt = CtrlRun;
                cnt_nxt   = '0;
            end
        endcase
    end

    assign stall_o = rst ? stall_raw : StallNone;
    assign busy_o  = (state == CtrlMc);

`ifdef STALL_CTRL_PERF_EN
    sat_counter u_stall_cnt (
        .clk   (clk),
        .rst   (rst),
        .en    (stall_o != StallNone),
        .count (stall_cycles_o)
    );

    sat_counter u_flush_cnt (
        .clk   (clk),
        .rst   (rst),
        .en    (flush_o),
        .count (flush_count_o)
    );
`endif

endmodule

// File: tb/tb_pipeline_ctrl.sv
// Directed-vector bench for pipeline_ctrl stall/flush sequencing.
module tb_pipeline_ctrl;
    import pipeline_ctrl_pkg::*;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        stallreq_id_i = 1'b0;
    logic        mc_start_i = 1'b0;
    logic [5:0]  mc_len_i = '0;
    logic        flush_req_i = 1'b0;
    logic [31:0] flush_pc_i = '0;
    logic [5:0]  stall_o;
    logic        flush_o;
    logic [31:0] new_pc_o;
    logic        busy_o;
`ifdef STALL_CTRL_PERF_EN
    logic [31:0] stall_cycles_o;
    logic [31:0] flush_count_o;
`endif

    int tests = 0;
    int fails = 0;

    pipeline_ctrl #(.MC_LEN_W(6)) dut (
        .clk            (clk),
        .rst            (rst),
        .stallreq_id_i  (stallreq_id_i),
        .mc_start_i     (mc_start_i),
        .mc_len_i       (mc_len_i),
        .flush_req_i    (flush_req_i),
        .flush_pc_i     (flush_pc_i),
        .stall_o        (stall_o),
        .flush_o        (flush_o),
        .new_pc_o       (new_pc_o),
`ifdef STALL_CTRL_PERF_EN
        .stall_cycles_o (stall_cycles_o),
        .flush_count_o  (flush_count_o),
`endif
        .busy_o         (busy_o)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        tests++;
        if (got !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // One cycle: drive just after the edge, return at the following negedge
    task automatic cyc(input logic sr, input logic mc, input logic [5:0] len,
                       input logic fr, input logic [31:0] pc);
        @(posedge clk);
        #1;
        stallreq_id_i = sr;
        mc_start_i    = mc;
        mc_len_i      = len;
        flush_req_i   = fr;
        flush_pc_i    = pc;
        @(negedge clk);
    endtask

    task automatic idle();
        cyc(1'b0, 1'b0, 6'd0, 1'b0, 32'h0);
    endtask

    initial begin
        repeat (2) @(negedge clk);
        check("rst_stall", {26'h0, stall_o}, 32'h0);
        check("rst_flush", {31'h0, flush_o}, 32'h0);
        check("rst_pc", new_pc_o, 32'h0);
        check("rst_busy", {31'h0, busy_o}, 32'h0);
        @(posedge clk);
        #1 rst = 1'b1;

        idle();
        check("idle_stall", {26'h0, stall_o}, 32'h0);
        check("idle_flush", {31'h0, flush_o}, 32'h0);

        for (int i = 0; i < 3; i++) begin
            cyc(1'b1, 1'b0, 6'd0, 1'b0, 32'h0);
            check("ld_use", {26'h0, stall_o}, 32'h07);
        end
        idle();
        check("ld_use_rel", {26'h0, stall_o}, 32'h0);

        cyc(1'b0, 1'b1, 6'd5, 1'b0, 32'h0);
        check("mc5_c0_stall", {26'h0, stall_o}, 32'h0F);
        check("mc5_c0_busy", {31'h0, busy_o}, 32'h0);
        for (int i = 1; i < 5; i++) begin
            cyc(1'b1, (i == 2), 6'd3, 1'b0, 32'h0);
            check("mc5_stall", {26'h0, stall_o}, 32'h0F);
            check("mc5_busy", {31'h0, busy_o}, 32'h1);
        end
        idle();
        check("mc5_end_stall", {26'h0, stall_o}, 32'h0);
        check("mc5_end_busy", {31'h0, busy_o}, 32'h0);

        cyc(1'b0, 1'b1, 6'd0, 1'b0, 32'h0);
        check("mc0_stall", {26'h0, stall_o}, 32'h0);
        idle();
        check("mc0_busy", {31'h0, busy_o}, 32'h0);

        cyc(1'b0, 1'b1, 6'd1, 1'b0, 32'h0);
        check("mc1_stall", {26'h0, stall_o}, 32'h0F);
        check("mc1_busy", {31'h0, busy_o}, 32'h0);
        idle();
        check("mc1_after_stall", {26'h0, stall_o}, 32'h0);
        check("mc1_after_busy", {31'h0, busy_o}, 32'h0);

        cyc(1'b0, 1'b1, 6'd10, 1'b0, 32'h0);
        check("mc10_c0", {26'h0, stall_o}, 32'h0F);
        idle();
        check("mc10_c1_busy", {31'h0, busy_o}, 32'h1);
        cyc(1'b0, 1'b0, 6'd0, 1'b1, 32'h0000_0100);
        check("mcfl_stall", {26'h0, stall_o}, 32'h0);
        check("mcfl_flush_pre", {31'h0, flush_o}, 32'h0);
        idle();
        check("mcfl_flush", {31'h0, flush_o}, 32'h1);
        check("mcfl_pc", new_pc_o, 32'h100);
        check("mcfl_busy", {31'h0, busy_o}, 32'h0);
        check("mcfl_fstall", {26'h0, stall_o}, 32'h0);
        idle();
        check("mcfl_done", {31'h0, flush_o}, 32'h0);
        check("mcfl_pc_hold", new_pc_o, 32'h100);
        check("mcfl_run_busy", {31'h0, busy_o}, 32'h0);

        cyc(1'b1, 1'b1, 6'd4, 1'b1, 32'h0000_0200);
        check("all_stall", {26'h0, stall_o}, 32'h0);
        idle();
        check("all_flush", {31'h0, flush_o}, 32'h1);
        check("all_pc", new_pc_o, 32'h200);
        check("all_busy", {31'h0, busy_o}, 32'h0);
        idle();
        check("all_done", {31'h0, flush_o}, 32'h0);
        check("all_done_busy", {31'h0, busy_o}, 32'h0);

        cyc(1'b0, 1'b0, 6'd0, 1'b1, 32'h0000_0300);
        cyc(1'b1, 1'b1, 6'd4, 1'b1, 32'h0000_0400);
        check("refl_stall", {26'h0, stall_o}, 32'h0);
        check("refl_first", new_pc_o, 32'h300);
        idle();
        check("refl_flush", {31'h0, flush_o}, 32'h1);
        check("refl_pc", new_pc_o, 32'h400);
        check("refl_busy", {31'h0, busy_o}, 32'h0);
        idle();
        check("refl_done", {31'h0, flush_o}, 32'h0);

        cyc(1'b0, 1'b1, 6'd10, 1'b0, 32'h0);
        idle();
        check("rmc_busy_pre", {31'h0, busy_o}, 32'h1);
        @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        check("rmc_stall", {26'h0, stall_o}, 32'h0);
        check("rmc_busy", {31'h0, busy_o}, 32'h0);
        @(posedge clk);
        #1 rst = 1'b1;
        idle();
        check("rmc_after", {31'h0, busy_o}, 32'h0);
        check("rmc_after_st", {26'h0, stall_o}, 32'h0);

        cyc(1'b0, 1'b0, 6'd0, 1'b1, 32'h0000_0500);
        idle();
        check("rfl_pre", {31'h0, flush_o}, 32'h1);
        @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        check("rfl_flush", {31'h0, flush_o}, 32'h0);
        check("rfl_pc", new_pc_o, 32'h0);
        @(posedge clk);
        #1 rst = 1'b1;
        idle();
        check("rfl_after", {31'h0, flush_o}, 32'h0);

`ifdef STALL_CTRL_PERF_EN
        @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        check("perf_rst_st", stall_cycles_o, 32'h0);
        check("perf_rst_fl", flush_count_o, 32'h0);
        @(posedge clk);
        #1 rst = 1'b1;
        for (int i = 0; i < 3; i++) cyc(1'b1, 1'b0, 6'd0, 1'b0, 32'h0);
        idle();
        check("perf_stall3", stall_cycles_o, 32'd3);
        cyc(1'b0, 1'b0, 6'd0, 1'b1, 32'h0000_0100);
        idle();
        idle();
        check("perf_flush1", flush_count_o, 32'd1);
        check("perf_stall_hold", stall_cycles_o, 32'd3);
`endif

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
